// File: rtl/mem_block_responder.sv
// mem_block_responder: memory-side responder serving 8-beat block reads and single-word writes
module mem_block_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 15,
  parameter int BEATS      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        busy,
  output logic        data_valid,
  output logic [15:0] data_out,
  output logic [15:0] data_addr,
  output logic [2:0]  beat_idx,
  output logic        last,
  output logic        wr_done
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] base;
  logic [15:0] mem [2**DEPTH_LOG2];
  logic [15:0] nxt_addr;
  logic        unused_ok;
  assign busy      = ~req_ready;
  assign nxt_addr  = (state == RD_BURST) ? data_addr + 16'd2 : base;
  assign unused_ok = ^{req_addr[0], nxt_addr[0]};
  // storage is deliberately outside the reset domain so contents survive reset
  always_ff @(posedge clk)
    if (state == IDLE && req_valid && req_wr) mem[req_addr[DEPTH_LOG2:1]] <= req_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      base       <= '0;
      req_ready  <= 1'b1;
      data_valid <= 1'b0;
      data_out   <= '0;
      data_addr  <= '0;
      beat_idx   <= '0;
      last       <= 1'b0;
      wr_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          cnt       <= 4'(LATENCY - 1);
          base      <= {req_addr[15:4], 4'h0};
          state     <= req_wr ? WR_WAIT : RD_WAIT;
        end
        RD_WAIT: if (cnt == 4'd0) begin
          state      <= RD_BURST;
          data_valid <= 1'b1;
          data_addr  <= nxt_addr;
          data_out   <= mem[nxt_addr[DEPTH_LOG2:1]];
          beat_idx   <= '0;
          last       <= 1'b0;
        end else cnt <= cnt - 4'd1;
        RD_BURST: if (beat_idx == 3'(BEATS - 1)) begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          data_valid <= 1'b0;
          data_out   <= '0;
          data_addr  <= '0;
          beat_idx   <= '0;
          last       <= 1'b0;
        end else begin
          data_addr <= nxt_addr;
          data_out  <= mem[nxt_addr[DEPTH_LOG2:1]];
          beat_idx  <= beat_idx + 3'd1;
          last      <= beat_idx == 3'(BEATS - 2);
        end
        WR_WAIT: if (wr_done) begin
          wr_done   <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end else if (cnt == 4'd0) wr_done <= 1'b1;
        else cnt <= cnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/mem_block_responder.md
Name: mem_block_responder

Overview:
- Memory-side responder for the cache fill protocol.
- Accepts one block-read or one word-write request at a time from the cache arbitration logic.
- After a fixed access latency, a read streams the 8 words of the aligned 16-byte block, one per cycle, each with a valid strobe, in ascending order 0,2,…,14.
- A single instance is shared by the instruction and data caches. It replaces per-word addressing from the fill FSM with a burst handshake.

Parameters:
- LATENCY, 4, cycles from request acceptance to first read beat / write completion; legal range 1..15
- DEPTH_LOG2, 15, log2 of the number of 16-bit words stored; word index = addr[DEPTH_LOG2:1]
- BEATS, 8, words per block burst; fixed at 8, block = 16 bytes

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present this cycle
- req_wr  in  1  1 = single-word write, 0 = block read
- req_addr  in  16  byte address; bit 0 ignored
- req_wdata  in  16  write data (req_wr=1)
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready
- busy  out  1  = ~req_ready
- data_valid  out  1  read beat valid
- data_out  out  16  read beat data; 16'h0000 when data_valid=0
- data_addr  out  16  byte address of current beat; 16'h0000 when data_valid=0
- beat_idx  out  3  beat number 0..7 of current beat
- last  out  1  data_valid & beat_idx==7
- wr_done  out  1  one-cycle pulse when an accepted write completes

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - Outputs: req_ready=1, busy=0, data_valid=0, data_out=0, data_addr=0, beat_idx=0, last=0, wr_done=0.
  - Storage array is NOT reset; contents survive reset.
  - Reset mid-burst or mid-write abandons the transaction with no further beats or wr_done. A write already committed stays committed.
- States: IDLE, RD_WAIT, RD_BURST, WR_WAIT.
- IDLE:
  - On accept with req_wr=0: latch base = {req_addr[15:4],4'h0}, load the latency counter, go to RD_WAIT.
  - On accept with req_wr=1: write req_wdata to word req_addr[DEPTH_LOG2:1] at the accept edge, load the counter, go to WR_WAIT.
- RD_WAIT: counter decrements each cycle. The first beat is presented in the cycle that begins LATENCY edges after the accept edge. Transition to RD_BURST at that point with beat_idx=0.
- RD_BURST:
  - 8 consecutive cycles with data_valid=1, no gaps.
  - Beat k: data_addr = base + 2k, data_out = mem[(base+2k)>>1].
  - After beat 7 (last=1), return to IDLE; req_ready rises the following cycle.
- WR_WAIT: after LATENCY edges, pulse wr_done for exactly one cycle, then return to IDLE in the next cycle.
- Only one transaction is outstanding. req_valid while busy is ignored and not queued; the requester must hold the request until req_ready. req_* inputs are not sampled outside IDLE.
- Read data reflects all writes accepted before the read's accept edge.
- The base address is block-aligned, so beats never wrap past the block and no address overflow is possible.
- Counter width: 4 bits. Beat counter: 3 bits, wraps 7→0 only on exit.

Test Plan:
1. Reset, then write 16'hA5A5 @0x0012 → req_ready low for LATENCY+1 cycles; wr_done pulses once, 4 cycles after accept (LATENCY=4); req_ready returns next cycle.
2. Write 8 words 0x1000+k at 0x0040+2k, then read req_addr=0x004B → first data_valid exactly 4 cycles after accept. Beats give data_addr 0x0040..0x004E and data_out 0x1000..0x1007, contiguous. last on beat 7 only. data_out=0 between beats of separate requests.
3. Hold req_valid high with a new read during a burst → no second accept until req_ready=1. The second burst starts LATENCY cycles after its accept, with no overlap with the first.
4. Assert rst_n=0 during beat 3 of a burst → data_valid/last/data_addr drop to 0 asynchronously. After release, req_ready=1. Reading the same block returns unchanged data.
5. Write with req_addr bit0=1 (0x0013) → same word as 0x0012 is overwritten. A subsequent block read of 0x0010 shows the new value at beat 1.
6. Sweep LATENCY=1 and 15 → first beat / wr_done at exactly 1 / 15 cycles after accept; burst still 8 beats.
